// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   BYTE_W      width of one transmitted byte
//   arb_state_t arbiter FSM states
//   width_for   bits needed to hold a count 0..max_val (at least 1)
//   idx_width   bits needed to index n items (at least 1)
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational rotate-priority picker.
//   req   in  N      request vector
//   last  in  IW     index of the previously granted requester
//   grant out IW     first requester after 'last' in circular order
//   any   out 1      at least one request is present
// The previous winner is checked last, which gives it lowest priority.
module rr_select
  import uart_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req,
  input  logic [idx_width(N)-1:0] last,
  output logic [idx_width(N)-1:0] grant,
  output logic                    any
);

  localparam int IW = idx_width(N);

  // cand[gi] is the requester at circular distance gi+1 from 'last'.
  logic [IW-1:0] cand [N];

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    // last < N, so sum < 2N: one conditional subtraction is a full modulo.
    assign sum = {1'b0, last} + (IW+1)'(gi + 1);
    assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  always_comb begin
    grant = last;
    any   = 1'b0;
    // Walk from the farthest candidate inwards so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant = cand[k];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter among N_SRC producers.
// A source is granted round-robin and keeps the grant until FRAME_BYTES bytes
// have been issued. Each byte is followed by one dead cycle so the UART has
// time to drop uart_ready before the next byte is considered.
// Optional feature macro: ARB_TIMEOUT_EN - aborts a frame whose source stalls
// mid-frame for TIMEOUT_CYC cycles.
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   src_valid    per-source byte available
//   src_data     per-source bytes, source 0 in the LSBs
//   src_ack      one-cycle pulse, byte of that source consumed
//   uart_ready   UART transmitter idle (level)
//   tx_data      byte to the UART, valid with tx_start
//   tx_start     one-cycle load pulse to the UART
//   grant_id     current / last granted source
//   busy         a frame is locked
//   frame_abort  one-cycle pulse on stall timeout (0 without ARB_TIMEOUT_EN)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int FRAME_BYTES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [BYTE_W*N_SRC-1:0]    src_data,
  output logic [N_SRC-1:0]           src_ack,
  input  logic                       uart_ready,
  output logic [BYTE_W-1:0]          tx_data,
  output logic                       tx_start,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       frame_abort
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = width_for(FRAME_BYTES);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SRC - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [N_SRC-1:0]   src_ack_q, src_ack_d;

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = width_for(TIMEOUT_CYC);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               frame_abort_q, frame_abort_d;
`endif

  // Byte lanes of the packed input bus.
  logic [BYTE_W-1:0] src_byte [N_SRC];
  genvar gi;
  for (gi = 0; gi < N_SRC; gi++) begin : g_lane
    assign src_byte[gi] = src_data[gi*BYTE_W +: BYTE_W];
  end

  logic [BYTE_W-1:0] cur_byte;
  logic              cur_valid;
  assign cur_byte  = src_byte[grant_id_q];
  assign cur_valid = src_valid[grant_id_q];

  logic [IDX_W-1:0] sel_grant;
  logic             sel_any;

  rr_select #(.N(N_SRC)) u_rr_select (
    .req   (src_valid),
    .last  (grant_id_q),
    .grant (sel_grant),
    .any   (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    byte_cnt_d = byte_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    src_ack_d  = '0;
`ifdef ARB_TIMEOUT_EN
    stall_cnt_d   = stall_cnt_q;
    frame_abort_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_id_d = sel_grant;
          busy_d     = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (uart_ready && cur_valid) begin
          tx_start_d            = 1'b1;
          tx_data_d             = cur_byte;
          src_ack_d[grant_id_q] = 1'b1;
          byte_cnt_d            = byte_cnt_q + CNT_W'(1);
          state_d               = ST_GAP;
`ifdef ARB_TIMEOUT_EN
          stall_cnt_d = '0;
        end else if (!cur_valid && (byte_cnt_q != '0)) begin
          // Only a source that went quiet mid-frame can time out; a
          // busy UART never triggers an abort.
          if (stall_cnt_q == STALL_LAST) begin
            frame_abort_d = 1'b1;
            stall_cnt_d   = '0;
            byte_cnt_d    = '0;
            busy_d        = 1'b0;
            state_d       = ST_IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
`endif
        end
      end
      ST_GAP: begin
        if (byte_cnt_q == FRAME_CNT) begin
          byte_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= LAST_IDX;
      busy_q     <= 1'b0;
      byte_cnt_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      src_ack_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      frame_abort_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      byte_cnt_q <= byte_cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      src_ack_q  <= src_ack_d;
`ifdef ARB_TIMEOUT_EN
      stall_cnt_q   <= stall_cnt_d;
      frame_abort_q <= frame_abort_d;
`endif
    end
  end

  assign src_ack  = src_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

`ifdef ARB_TIMEOUT_EN
  assign frame_abort = frame_abort_q;
`else
  assign frame_abort = 1'b0;
  // Keeps the timeout parameter referenced when the abort path is compiled out.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

endmodule
